text_writer: RTL and testbench

Character-stream writer for the 30×80 text screen buffer scanned by the VGA display path. It accepts bytes over a valid/ready handshake and interprets printable and control characters. It emits byte-lane writes into the 32-bit-word screen RAM, packed four characters per word with the most significant byte at the lowest column. It maintains the cursor and a hardware scroll base, so scrolling costs one row clear rather than a full buffer copy.

---
 rtl/text_writer_pkg.sv | 34 +++
 rtl/text_writer_if.sv | 20 ++
 rtl/text_writer_cursor.sv | 83 ++++++++
 rtl/text_writer.sv | 185 ++++++++++++++++++
 tb/tb_text_writer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_writer_pkg.sv
// Shared constants, state type and row arithmetic for the text screen writer.
package text_pkg;

   localparam int unsigned ROWS  = 30;
   localparam int unsigned COLS  = 80;
   localparam logic [7:0]  BLANK = 8'h20;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_FF = 8'h0C;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLR_ROW = 2'd1,
      ST_CLR_ALL = 2'd2
   } state_t;

   // Modulo-rows add; both operands are below rows, so one subtract suffices.
   function automatic logic [4:0] row_wrap(input logic [4:0] base,
                                           input logic [4:0] off,
                                           input int unsigned rows = ROWS);
      logic [5:0] sum;
      logic [5:0] res;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= 6'(rows)) begin
         res = sum - 6'(rows);
      end else begin
         res = sum;
      end
      return res[4:0];
   endfunction

endpackage

// File: rtl/text_writer_if.sv
// Byte input handshake plus screen RAM byte-lane write port of the text writer.
interface text_writer_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, wr_be
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, wr_be
   );
endinterface

// File: rtl/text_writer_cursor.sv
// Cursor row/col and scroll base registers for the text writer.
// TEXT_WRITER_SCROLL_EN selects scrolling; otherwise the cursor wraps to row 0.
module text_cursor
   import text_pkg::*;
#(
   parameter int unsigned N_ROWS = ROWS,
   parameter int unsigned N_COLS = COLS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_print,
   input  logic       cmd_lf,
   input  logic       cmd_cr,
   input  logic       cmd_bs,
   input  logic       cmd_ff,
   output logic [4:0] row,
   output logic [6:0] col,
   output logic [4:0] scroll_base
);

   localparam logic [4:0] LAST_ROW = 5'(N_ROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(N_COLS - 1);

   logic [4:0] row_r, row_s;
   logic [6:0] col_r, col_s;
   logic [4:0] base_r, base_s;

   // Next cursor position for the command accepted this cycle.
   always_comb begin
      row_s  = row_r;
      col_s  = col_r;
      base_s = base_r;
      if (cmd_ff) begin
         row_s  = 5'd0;
         col_s  = 7'd0;
         base_s = 5'd0;
      end else if (cmd_lf || (cmd_print && (col_r == LAST_COL))) begin
         col_s = 7'd0;
         if (row_r < LAST_ROW) begin
            row_s = row_r + 5'd1;
         end else begin
`ifdef TEXT_WRITER_SCROLL_EN
            base_s = row_wrap(base_r, 5'd1, N_ROWS);
`else
            row_s = 5'd0;
`endif
         end
      end else if (cmd_print) begin
         col_s = col_r + 7'd1;
      end else if (cmd_cr) begin
         col_s = 7'd0;
      end else if (cmd_bs) begin
         if (col_r != 7'd0) begin
            col_s = col_r - 7'd1;
         end else if (row_r != 5'd0) begin
            row_s = row_r - 5'd1;
            col_s = LAST_COL;
         end else begin
            col_s = col_r;
         end
      end else begin
         col_s = col_r;
      end
   end

   // Cursor state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_r  <= 5'd0;
         col_r  <= 7'd0;
         base_r <= 5'd0;
      end else begin
         row_r  <= row_s;
         col_r  <= col_s;
         base_r <= base_s;
      end
   end

   assign row         = row_r;
   assign col         = col_r;
   assign scroll_base = base_r;

endmodule

// File: rtl/text_writer.sv
// Character-stream writer into the packed 30x80 text screen RAM.
// TEXT_WRITER_SCROLL_EN enables hardware scrolling via scroll_base.
module text_writer #(
   parameter int unsigned ROWS  = text_pkg::ROWS,
   parameter int unsigned COLS  = text_pkg::COLS,
   parameter logic [7:0]  BLANK = text_pkg::BLANK
) (
   input  logic                CLOCK_50,
   input  logic                rst_n,
   text_writer_if.slave        bus,
   output logic [4:0]          cursor_row,
   output logic [6:0]          cursor_col,
   output logic [4:0]          scroll_base
);

   localparam int unsigned WORDS     = COLS / 4;
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_WORD = 5'(WORDS - 1);

   text_pkg::state_t state_r, state_s;
   logic [4:0]  clr_row_r, clr_row_s;
   logic [4:0]  clr_word_r, clr_word_s;
   logic        in_ready_r, in_ready_s;
   logic        wr_en_r, wr_en_s;
   logic [9:0]  wr_addr_r, wr_addr_s;
   logic [31:0] wr_data_r, wr_data_s;
   logic [3:0]  wr_be_r, wr_be_s;

   logic        accept_s, is_print_s, is_lf_s, is_cr_s, is_bs_s, is_ff_s;
   logic        need_clr_s;
   logic [4:0]  phys_s, phys_prev_s;
   logic [6:0]  col_m1_s;

   assign accept_s   = bus.in_valid & in_ready_r;
   assign is_print_s = accept_s && (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
   assign is_lf_s    = accept_s && (bus.in_data == text_pkg::CH_LF);
   assign is_cr_s    = accept_s && (bus.in_data == text_pkg::CH_CR);
   assign is_bs_s    = accept_s && (bus.in_data == text_pkg::CH_BS);
   assign is_ff_s    = accept_s && (bus.in_data == text_pkg::CH_FF);
   assign need_clr_s = (is_lf_s || (is_print_s && (cursor_col == LAST_COL)))
                       && (cursor_row == LAST_ROW);

   assign phys_s      = text_pkg::row_wrap(scroll_base, cursor_row, ROWS);
   assign phys_prev_s = text_pkg::row_wrap(scroll_base, cursor_row - 5'd1, ROWS);
   assign col_m1_s    = cursor_col - 7'd1;

   text_cursor #(
      .N_ROWS (ROWS),
      .N_COLS (COLS)
   ) u_cursor (
      .clk         (CLOCK_50),
      .rst_n       (rst_n),
      .cmd_print   (is_print_s),
      .cmd_lf      (is_lf_s),
      .cmd_cr      (is_cr_s),
      .cmd_bs      (is_bs_s),
      .cmd_ff      (is_ff_s),
      .row         (cursor_row),
      .col         (cursor_col),
      .scroll_base (scroll_base)
   );

   // State register; reset lands in the full clear so RAM contents are defined.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= text_pkg::ST_CLR_ALL;
         clr_row_r  <= 5'd0;
         clr_word_r <= 5'd0;
      end else begin
         state_r    <= state_s;
         clr_row_r  <= clr_row_s;
         clr_word_r <= clr_word_s;
      end
   end

   // Next state and clear-walk counters. The row to clear is the pre-scroll base.
   always_comb begin
      state_s    = state_r;
      clr_row_s  = clr_row_r;
      clr_word_s = clr_word_r;
      case (state_r)
         text_pkg::ST_IDLE: begin
            clr_word_s = 5'd0;
            clr_row_s  = is_ff_s ? 5'd0 : scroll_base;
            if (is_ff_s) begin
               state_s = text_pkg::ST_CLR_ALL;
            end else if (need_clr_s) begin
               state_s = text_pkg::ST_CLR_ROW;
            end else begin
               state_s = text_pkg::ST_IDLE;
            end
         end
         text_pkg::ST_CLR_ROW: begin
            clr_word_s = clr_word_r + 5'd1;
            if (clr_word_r == LAST_WORD) begin
               state_s = text_pkg::ST_IDLE;
            end else begin
               state_s = text_pkg::ST_CLR_ROW;
            end
         end
         text_pkg::ST_CLR_ALL: begin
            if (clr_word_r == LAST_WORD) begin
               clr_word_s = 5'd0;
               clr_row_s  = clr_row_r + 5'd1;
               if (clr_row_r == LAST_ROW) begin
                  state_s = text_pkg::ST_IDLE;
               end else begin
                  state_s = text_pkg::ST_CLR_ALL;
               end
            end else begin
               clr_word_s = clr_word_r + 5'd1;
            end
         end
         default: begin
            state_s = text_pkg::ST_IDLE;
         end
      endcase
   end

   // Write port and ready values to be registered at the next edge.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = 10'd0;
      wr_data_s = 32'd0;
      wr_be_s   = 4'd0;
      case (state_r)
         text_pkg::ST_IDLE: begin
            if (is_print_s) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {phys_s, cursor_col[6:2]};
               wr_data_s = {4{bus.in_data}};
               wr_be_s   = 4'b1000 >> cursor_col[1:0];
            end else if (is_bs_s && (cursor_col != 7'd0)) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {phys_s, col_m1_s[6:2]};
               wr_data_s = {4{BLANK}};
               wr_be_s   = 4'b1000 >> col_m1_s[1:0];
            end else if (is_bs_s && (cursor_row != 5'd0)) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {phys_prev_s, LAST_COL[6:2]};
               wr_data_s = {4{BLANK}};
               wr_be_s   = 4'b1000 >> LAST_COL[1:0];
            end else begin
               wr_en_s = 1'b0;
            end
         end
         text_pkg::ST_CLR_ROW, text_pkg::ST_CLR_ALL: begin
            wr_en_s   = 1'b1;
            wr_addr_s = {clr_row_r, clr_word_r};
            wr_data_s = {4{BLANK}};
            wr_be_s   = 4'b1111;
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
      // Ready only once IDLE has been held for a full cycle.
      in_ready_s = (state_r == text_pkg::ST_IDLE) && (state_s == text_pkg::ST_IDLE);
   end

   // Output registers.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= 10'd0;
         wr_data_r  <= 32'd0;
         wr_be_r    <= 4'd0;
      end else begin
         in_ready_r <= in_ready_s;
         wr_en_r    <= wr_en_s;
         wr_addr_r  <= wr_addr_s;
         wr_data_r  <= wr_data_s;
         wr_be_r    <= wr_be_s;
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.wr_en    = wr_en_r;
   assign bus.wr_addr  = wr_addr_r;
   assign bus.wr_data  = wr_data_r;
   assign bus.wr_be    = wr_be_r;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: a cursor model predicts every RAM write.
// Expectations follow TEXT_WRITER_SCROLL_EN the same way as the design build.
module tb_text_writer;
   import text_pkg::*;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   logic       CLOCK_50 = 1'b0;
   logic       rst_n;
   logic [4:0] cursor_row;
   logic [6:0] cursor_col;
   logic [4:0] scroll_base;

   text_writer_if bus ();

   text_writer dut (
      .CLOCK_50    (CLOCK_50),
      .rst_n       (rst_n),
      .bus         (bus),
      .cursor_row  (cursor_row),
      .cursor_col  (cursor_col),
      .scroll_base (scroll_base)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int  n_checks = 0;
   int  n_errors = 0;
   wr_t sb[$];
   int  mon_writes = 0;
   logic last_wr_rdy = 1'b0;
   time last_wr_t = 0;
   int  m_row, m_col, m_base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Write monitor: every RAM write must match the oldest predicted write.
   always @(negedge CLOCK_50) begin
      if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
         mon_writes++;
         last_wr_rdy = bus.in_ready;
         last_wr_t   = $time;
         if (sb.size() == 0) begin
            chk("unexp_wr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", bus.wr_data, e.data);
            chk("wr_be", 32'(bus.wr_be), 32'(e.be));
         end
      end
   end

   function automatic void exp_char(int prow, int c, logic [7:0] ch);
      wr_t e;
      e.addr = 10'((prow << 5) | (c >> 2));
      e.data = {4{ch}};
      e.be   = 4'(8 >> (c % 4));
      sb.push_back(e);
   endfunction

   function automatic void exp_row_clear(int prow);
      wr_t e;
      for (int w = 0; w < COLS / 4; w++) begin
         e.addr = 10'((prow << 5) | w);
         e.data = 32'h2020_2020;
         e.be   = 4'hF;
         sb.push_back(e);
      end
   endfunction

   function automatic void exp_full_clear();
      for (int r = 0; r < ROWS; r++) exp_row_clear(r);
   endfunction

   task automatic model_newline(output bit busy);
      int clr;
      busy  = 1'b0;
      m_col = 0;
      if (m_row < ROWS - 1) begin
         m_row++;
      end else begin
`ifdef TEXT_WRITER_SCROLL_EN
         clr    = m_base;
         m_base = (m_base + 1) % ROWS;
`else
         clr   = 0;
         m_row = 0;
`endif
         exp_row_clear(clr);
         busy = 1'b1;
      end
   endtask

   task automatic model_step(input logic [7:0] b, output bit wr, output bit busy);
      int phys;
      wr   = 1'b0;
      busy = 1'b0;
      phys = (m_base + m_row) % ROWS;
      if (b >= 8'h20 && b <= 8'h7E) begin
         exp_char(phys, m_col, b);
         wr = 1'b1;
         if (m_col == COLS - 1) model_newline(busy);
         else m_col++;
      end else if (b == CH_LF) begin
         model_newline(busy);
      end else if (b == CH_CR) begin
         m_col = 0;
      end else if (b == CH_BS) begin
         if (m_col > 0) begin
            m_col--;
            exp_char(phys, m_col, BLANK);
            wr = 1'b1;
         end else if (m_row > 0) begin
            m_row--;
            m_col = COLS - 1;
            exp_char((m_base + m_row) % ROWS, m_col, BLANK);
            wr = 1'b1;
         end
      end else if (b == CH_FF) begin
         m_row = 0; m_col = 0; m_base = 0;
         exp_full_clear();
         busy = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      bit wr, busy;
      int guard = 0;
      @(negedge CLOCK_50);
      while (bus.in_ready !== 1'b1 && guard < 2000) begin
         @(negedge CLOCK_50);
         guard++;
      end
      if (bus.in_ready !== 1'b1) begin
         chk("ready_to", 32'(bus.in_ready), 32'd1);
         return;
      end
      model_step(b, wr, busy);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge CLOCK_50);
      #1;
      bus.in_valid = 1'b0;
      chk("wr_lat", 32'(bus.wr_en), 32'(wr));
      chk("rdy_after", 32'(bus.in_ready), 32'(!busy));
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((sb.size() != 0 || bus.in_ready !== 1'b1) && guard < 5000) begin
         @(posedge CLOCK_50);
         #1;
         guard++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic chk_cursor(input string tag);
      chk({tag, "_row"}, 32'(cursor_row), 32'(m_row));
      chk({tag, "_col"}, 32'(cursor_col), 32'(m_col));
      chk({tag, "_base"}, 32'(scroll_base), 32'(m_base));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_wen"}, 32'(bus.wr_en), 32'd0);
      chk({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
      chk({tag, "_data"}, bus.wr_data, 32'd0);
      chk({tag, "_be"}, 32'(bus.wr_be), 32'd0);
      chk({tag, "_row"}, 32'(cursor_row), 32'd0);
      chk({tag, "_col"}, 32'(cursor_col), 32'd0);
      chk({tag, "_base"}, 32'(scroll_base), 32'd0);
   endtask

   initial begin
      int start, guard;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      m_row = 0; m_col = 0; m_base = 0;
      #2;
      chk_reset_outputs("rst");

      // Power-up clear: 600 writes, ready one cycle after the last.
      start = mon_writes;
      exp_full_clear();
      #20 rst_n = 1'b1;
      drain("boot_drain");
      chk("boot_cnt", 32'(mon_writes - start), 32'd600);
      chk("rdy_lastwr", 32'(last_wr_rdy), 32'd0);
      chk("rdy_rise", 32'($time - last_wr_t), 32'd6);
      chk_cursor("boot");

      // 'A' at (0,0), spaces to col 5, then 'B'.
      send(8'h41);
      for (int i = 0; i < 4; i++) send(8'h20);
      send(8'h42);
      drain("ab_drain");
      chk_cursor("ab");

      // Ignored code and carriage return.
      send(8'h01);
      send(CH_CR);
      chk_cursor("cr");

      // Backspace at (0,0) is a no-op; at (3,0) it wraps to (2,79).
      send(CH_BS);
      chk_cursor("bs00");
      for (int i = 0; i < 3; i++) send(CH_LF);
      send(CH_BS);
      drain("bs_drain");
      chk_cursor("bs30");

      // Walk to the last row and fill it back to back to force a scroll/wrap.
      send(CH_CR);
      while (m_row < ROWS - 1) send(CH_LF);
      for (int i = 0; i < COLS; i++) send(8'h78);
      drain("scroll_drain");
      chk_cursor("scroll");
      send(8'h2A);
      drain("post_scroll_drain");
      chk_cursor("post_scroll");

      // Form feed mid-screen with in_valid held during the clear.
      send(8'h4D);
      send(CH_FF);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      repeat (50) @(posedge CLOCK_50);
      #1 bus.in_valid = 1'b0;
      drain("ff_drain");
      chk_cursor("ff");

      // Reset 100 writes into a clear, then the clear restarts at word 0.
      send(CH_FF);
      start = mon_writes;
      guard = 0;
      while (mon_writes < start + 100 && guard < 1000) begin
         @(posedge CLOCK_50);
         guard++;
      end
      chk("mid_cnt", 32'(mon_writes - start), 32'd100);
      #3 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      sb.delete();
      m_row = 0; m_col = 0; m_base = 0;
      exp_full_clear();
      repeat (3) @(negedge CLOCK_50);
      #2 rst_n = 1'b1;
      drain("rerst_drain");
      chk_cursor("rerst");
      send(8'h51);
      drain("final_drain");
      chk_cursor("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
